// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, visible-region flag, sync pulses
// delayed one cycle to match a registered colour stage, and a per-frame tick/counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       tick_next;

  always_comb begin
    h_next = DrawX + 10'd1;
    v_next = DrawY;
    if (DrawX == H_MAX) begin
      h_next = 10'd0;
      v_next = (DrawY == V_MAX) ? 10'd0 : DrawY + 10'd1;
    end
    tick_next = (h_next == 10'd0) && (v_next == V_ACT);
  end

  // blank and frame_tick decode the next counter values so they line up with
  // DrawX/DrawY; hs/vs decode the current values so they trail by one cycle.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_tick  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      DrawX      <= h_next;
      DrawY      <= v_next;
      blank      <= (h_next < H_ACT) && (v_next < V_ACT);
      hs         <= !((DrawX >= HS_FIRST) && (DrawX <= HS_LAST));
      vs         <= !((DrawY >= VS_FIRST) && (DrawY <= VS_LAST));
      frame_tick <= tick_next;
      if (tick_next) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a
// small-timing instance for frame-level behaviour within a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  a_x, a_y, b_x, b_y;
  logic        a_blank, a_hs, a_vs, a_tick, b_blank, b_hs, b_vs, b_tick;
  logic [15:0] a_fc, b_fc;

  vga_timing_gen dut_a (
    .vga_clk(clk), .reset(reset), .DrawX(a_x), .DrawY(a_y), .blank(a_blank),
    .hs(a_hs), .vs(a_vs), .frame_tick(a_tick), .frame_count(a_fc)
  );

  // H total 16 (sync on h 10..12), V total 9 (sync on v 5..6), frame 144 cycles
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .vga_clk(clk), .reset(reset), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
    .hs(b_hs), .vs(b_vs), .frame_tick(b_tick), .frame_count(b_fc)
  );

  int passed = 0;
  int total  = 0;
  int edges  = 0;

  typedef struct {
    int          n;
    bit          sel;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        tick;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    edges++;
  endtask

  function automatic logic [39:0] pack_a();
    return {a_x, a_y, a_blank, a_hs, a_vs, a_tick, a_fc};
  endfunction

  function automatic logic [39:0] pack_b();
    return {b_x, b_y, b_blank, b_hs, b_vs, b_tick, b_fc};
  endfunction

  function automatic logic [39:0] pack_v(input vec_t v);
    return {v.x, v.y, v.blank, v.hs, v.vs, v.tick, v.fc};
  endfunction

  localparam logic [39:0] RESET_VAL = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};

  initial begin
    int lows, runs, vlows, ticks, waited;
    logic prev_hs;

    //      n     sel  x    y  bl hs vs tk fc
    tbl[0]  = '{1,    0, 1,   0, 1, 1, 1, 0, 0};
    tbl[1]  = '{1,    1, 1,   0, 1, 1, 1, 0, 0};
    tbl[2]  = '{7,    1, 7,   0, 1, 1, 1, 0, 0};
    tbl[3]  = '{8,    1, 8,   0, 0, 1, 1, 0, 0};
    tbl[4]  = '{11,   1, 11,  0, 0, 0, 1, 0, 0};
    tbl[5]  = '{13,   1, 13,  0, 0, 0, 1, 0, 0};
    tbl[6]  = '{14,   1, 14,  0, 0, 1, 1, 0, 0};
    tbl[7]  = '{16,   1, 0,   1, 1, 1, 1, 0, 0};
    tbl[8]  = '{63,   1, 15,  3, 0, 1, 1, 0, 0};
    tbl[9]  = '{64,   1, 0,   4, 0, 1, 1, 1, 1};
    tbl[10] = '{65,   1, 1,   4, 0, 1, 1, 0, 1};
    tbl[11] = '{80,   1, 0,   5, 0, 1, 1, 0, 1};
    tbl[12] = '{81,   1, 1,   5, 0, 1, 0, 0, 1};
    tbl[13] = '{112,  1, 0,   7, 0, 1, 0, 0, 1};
    tbl[14] = '{113,  1, 1,   7, 0, 1, 1, 0, 1};
    tbl[15] = '{144,  1, 0,   0, 1, 1, 1, 0, 1};
    tbl[16] = '{208,  1, 0,   4, 0, 1, 1, 1, 2};
    tbl[17] = '{639,  0, 639, 0, 1, 1, 1, 0, 0};
    tbl[18] = '{640,  0, 640, 0, 0, 1, 1, 0, 0};
    tbl[19] = '{656,  0, 656, 0, 0, 1, 1, 0, 0};
    tbl[20] = '{657,  0, 657, 0, 0, 0, 1, 0, 0};
    tbl[21] = '{752,  0, 752, 0, 0, 0, 1, 0, 0};
    tbl[22] = '{753,  0, 753, 0, 0, 1, 1, 0, 0};
    tbl[23] = '{799,  0, 799, 0, 0, 1, 1, 0, 0};
    tbl[24] = '{800,  0, 0,   1, 1, 1, 1, 0, 0};
    tbl[25] = '{1599, 0, 799, 1, 0, 1, 1, 0, 0};
    tbl[26] = '{1600, 0, 0,   2, 1, 1, 1, 0, 0};

    // held in reset
    repeat (3) @(negedge clk);
    check("reset_a", {24'd0, pack_a()}, {24'd0, RESET_VAL});
    check("reset_b", {24'd0, pack_b()}, {24'd0, RESET_VAL});

    reset = 1'b0;
    edges = 0;
    for (int i = 0; i < 27; i++) begin
      while (edges < tbl[i].n) step();
      if (tbl[i].sel)
        check($sformatf("vec%0d_b_n%0d", i, tbl[i].n), {24'd0, pack_b()}, {24'd0, pack_v(tbl[i])});
      else
        check($sformatf("vec%0d_a_n%0d", i, tbl[i].n), {24'd0, pack_a()}, {24'd0, pack_v(tbl[i])});
    end

    // one full line of A: single hs pulse of 96 cycles, period 800
    lows = 0; runs = 0; prev_hs = a_hs;
    for (int i = 0; i < 800; i++) begin
      step();
      if (!a_hs) lows++;
      if (prev_hs && !a_hs) runs++;
      prev_hs = a_hs;
    end
    check("hs_low_cycles", 64'(lows), 64'd96);
    check("hs_pulses", 64'(runs), 64'd1);
    check("line_period", {44'd0, a_x, a_y}, {44'd0, 10'd0, 10'd3});

    // one full frame of B: vs low 2 lines, one tick
    vlows = 0; ticks = 0;
    for (int i = 0; i < 144; i++) begin
      step();
      if (!b_vs) vlows++;
      if (b_tick) ticks++;
    end
    check("vs_low_cycles", 64'(vlows), 64'd32);
    check("ticks_per_frame", 64'(ticks), 64'd1);

    // preload frame_count to 0xFFFF; the next tick must wrap it to 0
    force dut_b.frame_count = 16'hFFFF;
    #1;
    release dut_b.frame_count;
    waited = 0;
    do begin step(); waited++; end while (!b_tick && waited < 200);
    check("wrap_tick_seen", 64'(b_tick), 64'd1);
    check("frame_count_wrap", 64'(b_fc), 64'd0);
    waited = 0;
    do begin step(); waited++; end while (!b_tick && waited < 200);
    check("count_after_wrap", 64'(b_fc), 64'd1);

    // async reset in the middle of a line, between clock edges
    waited = 0;
    while (a_x != 10'd300 && waited < 800) begin step(); waited++; end
    check("reached_x300", 64'(a_x), 64'd300);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_a", {24'd0, pack_a()}, {24'd0, RESET_VAL});
    check("async_reset_b", {24'd0, pack_b()}, {24'd0, RESET_VAL});
    @(negedge clk);
    reset = 1'b0;
    step();
    check("restart_a", {24'd0, pack_a()}, {24'd0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0});
    check("restart_b_fc", 64'(b_fc), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives the pixel coordinates and the display-active flag consumed by the sprite/colour stage.
- Drives the hs/vs sync outputs to the DAC/connector, delayed to line up with that stage's one-cycle registered colour output.
- Provides a once-per-frame tick and a frame counter for game-logic updates (ball/player motion).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
vga_clk  input  1  pixel clock (25 MHz); all logic on posedge
reset  input  1  asynchronous, active-high reset
DrawX  output  10  current pixel column (horizontal counter)
DrawY  output  10  current line (vertical counter)
blank  output  1  1 = pixel in visible region (colour stage drives RGB only when 1)
hs  output  1  horizontal sync, active low, delayed 1 cycle vs DrawX
vs  output  1  vertical sync, active low, delayed 1 cycle vs DrawY
frame_tick  output  1  one-cycle pulse at start of vertical blanking
frame_count  output  16  frames completed, wraps

Behaviour:
- One clock (vga_clk); reset is asynchronous and active-high.
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (async assert, held): DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_tick=0, frame_count=0.
- Horizontal counter h:
  - Increments every posedge while reset is low.
  - At h=H_TOTAL-1 it wraps to 0 and increments the vertical counter v.
  - v wraps to 0 when h wraps and v=V_TOTAL-1.
  - Simultaneous wraps (h=799, v=524) go to (0,0) on one edge.
- DrawX=h, DrawY=v, both registered.
- blank is registered on the same edge from the next counter values: blank=1 iff h<H_ACTIVE and v<V_ACTIVE. blank is therefore coincident with DrawX/DrawY, never a cycle late.
- First posedge after reset release: DrawX=1, DrawY=0, blank=1.
- hs and vs are sync decodes registered one cycle after DrawX/DrawY:
  - hs=0 on the cycle after h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751]; otherwise 1.
  - vs=0 on the cycle after v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491]; otherwise 1.
  - This compensates the colour stage's posedge RGB register, so sync and colour leave aligned.
- DrawX/DrawY are stable for the full period between posedges, so the colour stage may read its ROM on negedge.
- frame_tick:
  - 1 for exactly one cycle when DrawX=0 and DrawY=V_ACTIVE (registered alongside DrawX).
  - frame_count increments on that same edge and wraps 0xFFFF -> 0x0000.
- Counters never exceed TOTAL-1; no out-of-range coordinate is ever produced.
- Reset mid-frame: all outputs return immediately (async) to reset values. The raster restarts at (0,0) after release, with no partial tick.
- Arithmetic: counter widths are 10 bits. Compares use parameter sums computed at elaboration; no run-time division.

Test Plan:
- Reset release -> the first 640 cycles give DrawX 1..639 then 640 with DrawY=0; blank=1 for DrawX 1..639 and 0 at DrawX=640..799.
- Line wrap -> DrawX 799 is followed by DrawX 0 with DrawY incremented by 1; line period is exactly 800 cycles; blank returns to 1 at DrawX=0 for DrawY<480.
- hs timing -> hs low for exactly 96 consecutive cycles per line, starting the cycle after DrawX=656 and ending after DrawX=751 is registered; high otherwise.
- vs and frame timing:
  - vs low for exactly 1600 cycles, during the cycles after DrawY=490..491.
  - Frame period is 420000 cycles.
  - frame_tick pulses once per frame, at DrawX=0, DrawY=480.
  - frame_count goes 0 -> 1 -> 2 over two frames.
- Counter wrap -> force/preload frame_count to 0xFFFF (or run via a short-timing parameter set); the next frame_tick gives frame_count=0x0000.
- Async reset mid-line (DrawX=300, DrawY=200), asserted between clock edges -> outputs go to reset values without waiting for an edge; after release, DrawX=1, DrawY=0, frame_count=0.
